// File: rtl/switch_debounce.sv
// switch_debounce: input conditioning for the slide-switch bus and confirm button.
// Synchronises raw inputs, debounces the 16-bit switch word as one unit, and runs
// a four-state button FSM that yields a debounced level, a one-cycle press pulse
// and a sticky CPU-cleared press flag.
// Optional build macro SWITCH_SNAPSHOT_EN: switch_stable is loaded only in the
// cycle after confirm_pulse, freezing the word at confirmation time.
module switch_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] switch_raw,
  input  logic        confirm_raw,
  input  logic        confirm_clear,
  output logic [15:0] switch_stable,
  output logic        confirm_pulse,
  output logic        confirm_level,
  output logic        confirm_flag
);

  localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } btn_state_t;

  logic [15:0]            r_sw_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_btn_sync;
  logic [15:0]            w_sw_s;
  logic                   w_btn_s;

  logic [15:0]            r_cand;
  logic [CW-1:0]          r_cnt;
  logic [15:0]            r_sw_acc;

  btn_state_t             r_state;
  btn_state_t             w_state_nxt;
  logic [CW-1:0]          r_bcnt;
  logic [CW-1:0]          w_bcnt_nxt;
  logic                   r_pulse;
  logic                   r_level;
  logic                   w_pulse_nxt;
  logic                   w_level_nxt;
  logic                   r_flag;

  // Multi-flop synchronisers for every switch bit and the button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sw_sync[i] <= '0;
      end
      r_btn_sync <= '0;
    end else begin
      r_sw_sync[0] <= switch_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sw_sync[i] <= r_sw_sync[i-1];
      end
      r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], confirm_raw};
    end
  end

  assign w_sw_s  = r_sw_sync[SYNC_STAGES-1];
  assign w_btn_s = r_btn_sync[SYNC_STAGES-1];

  // Whole-bus debounce: any bit change restarts the stability count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cand   <= '0;
      r_cnt    <= '0;
      r_sw_acc <= '0;
    end else if (w_sw_s != r_cand) begin
      r_cand <= w_sw_s;
      r_cnt  <= '0;
    end else if (r_cnt < CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_sw_acc <= r_cand;
    end
  end

`ifdef SWITCH_SNAPSHOT_EN
  logic [15:0] r_switch_stable;

  // Capture the accepted switch word only when a press is confirmed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_switch_stable <= '0;
    end else if (r_pulse) begin
      r_switch_stable <= r_sw_acc;
    end
  end

  assign switch_stable = r_switch_stable;
`else
  assign switch_stable = r_sw_acc;
`endif

  // Button FSM state, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_bcnt  <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Button FSM next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_bcnt_nxt  = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_btn_s) begin
          w_state_nxt = ST_IDLE;
        end else if (r_bcnt == CNT_MAX) begin
          w_state_nxt = ST_HELD;
        end else begin
          w_bcnt_nxt = r_bcnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!w_btn_s) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_bcnt_nxt  = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_btn_s) begin
          w_state_nxt = ST_HELD;
        end else if (r_bcnt == CNT_MAX) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_bcnt_nxt = r_bcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_bcnt_nxt  = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so level/pulse leave a flop.
  // Only a PRESS_WAIT->HELD transition pulses; a bounce back from RELEASE_WAIT does not.
  always_comb begin
    w_level_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE_WAIT);
    w_pulse_nxt = (r_state == ST_PRESS_WAIT) && (w_state_nxt == ST_HELD);
  end

  // Sticky press flag: a pulse sets it, CPU clear drops it, set has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flag <= 1'b0;
    end else if (r_pulse) begin
      r_flag <= 1'b1;
    end else if (confirm_clear) begin
      r_flag <= 1'b0;
    end
  end

  assign confirm_pulse = r_pulse;
  assign confirm_level = r_level;
  assign confirm_flag  = r_flag;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed self-checking bench for switch_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Expected switch words depend on whether SWITCH_SNAPSHOT_EN is defined.
module tb_switch_debounce;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] switch_raw;
  logic        confirm_raw;
  logic        confirm_clear;
  logic [15:0] switch_stable;
  logic        confirm_pulse;
  logic        confirm_level;
  logic        confirm_flag;

  int checks   = 0;
  int failures = 0;
  int pulses;

`ifdef SWITCH_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  always #5 clk = ~clk;

  switch_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .switch_raw   (switch_raw),
    .confirm_raw  (confirm_raw),
    .confirm_clear(confirm_clear),
    .switch_stable(switch_stable),
    .confirm_pulse(confirm_pulse),
    .confirm_level(confirm_level),
    .confirm_flag (confirm_flag)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst           = 1'b0;
    switch_raw    = 16'hFFFF;
    confirm_raw   = 1'b1;
    confirm_clear = 1'b0;

    // Reset held with active inputs
    tick(3);
    chk("rst_stable", switch_stable, 16'h0000);
    chk("rst_pulse",  16'(confirm_pulse), 16'h0);
    chk("rst_level",  16'(confirm_level), 16'h0);
    chk("rst_flag",   16'(confirm_flag),  16'h0);

    // Release: switch word and press accepted 6 edges after the sampling edge
    rst = 1'b1;
    tick(6);
    chk("t1_stable_early", switch_stable, 16'h0000);
    chk("t1_pulse_early",  16'(confirm_pulse), 16'h0);
    tick(1);
    chk("t1_stable_accept", switch_stable, SNAP ? 16'h0000 : 16'hFFFF);
    chk("t1_pulse",         16'(confirm_pulse), 16'h1);
    chk("t1_level",         16'(confirm_level), 16'h1);
    tick(1);
    chk("t1_stable_after", switch_stable, 16'hFFFF);
    chk("t1_pulse_drop",   16'(confirm_pulse), 16'h0);
    chk("t1_flag",         16'(confirm_flag),  16'h1);
    pulses = 0;
    repeat (10) begin
      tick(1);
      pulses += int'(confirm_pulse);
    end
    chk("t1_no_extra_pulse", 16'(pulses), 16'h0);

    // Button release debounce
    confirm_raw = 1'b0;
    tick(6);
    chk("rel_level_held", 16'(confirm_level), 16'h1);
    tick(1);
    chk("rel_level_drop", 16'(confirm_level), 16'h0);

    // Flag clear, then clear while already 0
    confirm_clear = 1'b1;
    tick(1);
    confirm_clear = 1'b0;
    chk("clr_flag", 16'(confirm_flag), 16'h0);
    tick(1);
    confirm_clear = 1'b1;
    tick(1);
    confirm_clear = 1'b0;
    chk("clr_flag_idle", 16'(confirm_flag), 16'h0);

    // Switch word change latency
    switch_raw = 16'h0000;
    tick(8);
    chk("t2_base", switch_stable, SNAP ? 16'hFFFF : 16'h0000);
    switch_raw = 16'h00A5;
    tick(6);
    chk("t2_edge5", switch_stable, SNAP ? 16'hFFFF : 16'h0000);
    tick(1);
    chk("t2_edge6", switch_stable, SNAP ? 16'hFFFF : 16'h00A5);
    switch_raw = 16'h0000;
    tick(8);
    chk("t2_back", switch_stable, SNAP ? 16'hFFFF : 16'h0000);

    // Short glitch on bit0 never accepted
    switch_raw = 16'h0001;
    repeat (3) begin
      tick(1);
      chk("t3_glitch", switch_stable, SNAP ? 16'hFFFF : 16'h0000);
    end
    switch_raw = 16'h0000;
    repeat (10) begin
      tick(1);
      chk("t3_glitch", switch_stable, SNAP ? 16'hFFFF : 16'h0000);
    end

    // Long hold gives exactly one pulse
    pulses = 0;
    confirm_raw = 1'b1;
    repeat (20) begin
      tick(1);
      pulses += int'(confirm_pulse);
    end
    chk("t4_one_pulse", 16'(pulses), 16'h1);
    chk("t4_level",     16'(confirm_level), 16'h1);
    chk("t4_flag",      16'(confirm_flag),  16'h1);
    chk("t4_stable",    switch_stable, 16'h0000);
    confirm_raw = 1'b0;
    tick(8);
    chk("t4_level_rel", 16'(confirm_level), 16'h0);
    confirm_clear = 1'b1;
    tick(1);
    confirm_clear = 1'b0;
    chk("t4_flag_clr", 16'(confirm_flag), 16'h0);

    // New switch word with no press
    switch_raw = 16'h1234;
    tick(10);
    chk("t7_no_press", switch_stable, SNAP ? 16'h0000 : 16'h1234);

    // Bounce 1,0,1 inside PRESS_WAIT, then steady high
    confirm_raw = 1'b1;
    tick(1);
    confirm_raw = 1'b0;
    tick(1);
    confirm_raw = 1'b1;
    pulses = 0;
    repeat (6) begin
      tick(1);
      pulses += int'(confirm_pulse);
    end
    chk("t4_bounce_nopulse", 16'(pulses), 16'h0);
    chk("t4_bounce_level",   16'(confirm_level), 16'h0);
    tick(1);
    chk("t4_bounce_pulse",   16'(confirm_pulse), 16'h1);

    // Clear coincident with the pulse: set wins
    confirm_clear = 1'b1;
    tick(1);
    confirm_clear = 1'b0;
    chk("t5_set_wins",   16'(confirm_flag), 16'h1);
    chk("t5_pulse_one",  16'(confirm_pulse), 16'h0);
    chk("t7_snapshot",   switch_stable, 16'h1234);
    tick(2);
    chk("t5_flag_hold",  16'(confirm_flag), 16'h1);
    confirm_clear = 1'b1;
    tick(1);
    confirm_clear = 1'b0;
    chk("t5_flag_clr",   16'(confirm_flag), 16'h0);

    // Prepare a set flag and settled switch word before a mid-debounce reset
    confirm_raw = 1'b0;
    tick(8);
    chk("t6_level_idle", 16'(confirm_level), 16'h0);
    switch_raw = 16'h5A5A;
    tick(10);
    chk("t6_sw_settle", switch_stable, SNAP ? 16'h1234 : 16'h5A5A);
    confirm_raw = 1'b1;
    tick(8);
    chk("t6_flag_set",  16'(confirm_flag), 16'h1);
    chk("t6_sw_press",  switch_stable, 16'h5A5A);
    confirm_raw = 1'b0;
    tick(8);
    chk("t6_level_rel", 16'(confirm_level), 16'h0);
    confirm_raw = 1'b1;
    tick(4);

    // Reset while in PRESS_WAIT
    rst = 1'b0;
    #1;
    chk("t6_rst_level",  16'(confirm_level), 16'h0);
    chk("t6_rst_pulse",  16'(confirm_pulse), 16'h0);
    chk("t6_rst_flag",   16'(confirm_flag),  16'h0);
    chk("t6_rst_stable", switch_stable, 16'h0000);
    tick(2);
    chk("t6_rst_flag_hold", 16'(confirm_flag), 16'h0);

    // Full re-debounce after release with button and switches still held
    rst = 1'b1;
    pulses = 0;
    repeat (6) begin
      tick(1);
      pulses += int'(confirm_pulse);
    end
    chk("t6_no_early_pulse", 16'(pulses), 16'h0);
    chk("t6_stable_early",   switch_stable, 16'h0000);
    tick(1);
    chk("t6_pulse",          16'(confirm_pulse), 16'h1);
    chk("t6_stable_accept",  switch_stable, SNAP ? 16'h0000 : 16'h5A5A);
    tick(1);
    chk("t6_stable_after",   switch_stable, 16'h5A5A);
    chk("t6_flag_after",     16'(confirm_flag), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
